// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and types for the memory access unit
package mem_access_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Bus transfer sizes in bytes
    localparam logic [2:0] SZ_B = 3'd1;
    localparam logic [2:0] SZ_H = 3'd2;
    localparam logic [2:0] SZ_W = 3'd4;

    // Bus address map: low 16 bits are the offset, top bits select the region
    localparam int OFFSET_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Bit index of the IO-select flag within the bus address
    function automatic int io_sel_bit(input int addr_w);
        return addr_w - 1;
    endfunction

    // Bit index of the RAM(1)/flash(0) flag within the bus address
    function automatic int ram_sel_bit(input int addr_w);
        return addr_w - 2;
    endfunction

    // Transfer size implied by funct3[1:0]
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    // 3'b011 and 3'b11x have no load/store meaning here
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - sign/zero extension of raw bus read data by funct3
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Extend the low byte/halfword according to the load type; words pass through
    always_comb begin
        ext = raw;
        case (funct3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  ext = {24'd0, raw[7:0]};
            F3_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - arbitrates fetch and load/store ports onto the mem_bus request interface
module mem_access_unit #(
    parameter int          ADDR_W      = 18,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [2:0]        data_funct3,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_ready,
    output logic [31:0]       data_rdata,
    output logic              data_fault,
    output logic              bus_start_request,
    output logic [ADDR_W-1:0] bus_target_address,
    output logic [2:0]        bus_num_bytes,
    output logic              bus_is_write,
    output logic [31:0]       bus_write_value,
    input  logic              bus_request_done,
    input  logic [31:0]       bus_fetched_value
);
    import mem_access_pkg::*;

    localparam logic [31:0] WD_LAST = (TIMEOUT_CYC == 0) ? 32'd0 : TIMEOUT_CYC - 1;

    state_t      state, state_next;
    logic        grant_data;
    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [31:0] wd_cnt;
    logic [31:0] ext_data;

    logic        sel_data, sel_valid, sel_fault;
    logic [31:0] sel_addr;
    logic [2:0]  sel_size;
    logic        do_issue, do_reject, do_done, do_timeout;

    mem_load_align u_align (
        .funct3 (cur_funct3),
        .raw    (bus_fetched_value),
        .ext    (ext_data)
    );

    // Select the requesting port (data wins) and check range, alignment and funct3
    always_comb begin
        sel_data  = data_req;
        // a request still held during its own response pulse must not be taken again
        sel_valid = (data_req | fetch_req) & ~(fetch_ready | data_ready);
        sel_addr  = data_req ? data_addr : fetch_addr;
        sel_size  = data_req ? size_of(data_funct3) : SZ_W;
        sel_fault = 1'b0;
        if (data_req && f3_illegal(data_funct3))
            sel_fault = 1'b1;
        if ((sel_addr >> ADDR_W) != 32'd0)
            sel_fault = 1'b1;
        if ((sel_size == SZ_H) && sel_addr[0])
            sel_fault = 1'b1;
        if ((sel_size == SZ_W) && (sel_addr[1:0] != 2'b00))
            sel_fault = 1'b1;
    end

    // Next-state and transaction strobes
    always_comb begin
        state_next = state;
        do_issue   = 1'b0;
        do_reject  = 1'b0;
        do_done    = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_fault) begin
                        do_reject = 1'b1;
                    end else begin
                        do_issue   = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_request_done) begin
                    do_done    = 1'b1;
                    state_next = RELEASE;
                end else if ((TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST)) begin
                    do_timeout = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus_request_done)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, bus request registers, watchdog and response pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            grant_data         <= 1'b0;
            cur_we             <= 1'b0;
            cur_funct3         <= F3_LW;
            wd_cnt             <= 32'd0;
            bus_start_request  <= 1'b0;
            bus_target_address <= '0;
            bus_num_bytes      <= 3'd0;
            bus_is_write       <= 1'b0;
            bus_write_value    <= 32'd0;
            fetch_ready        <= 1'b0;
            fetch_instr        <= 32'd0;
            fetch_fault        <= 1'b0;
            data_ready         <= 1'b0;
            data_rdata         <= 32'd0;
            data_fault         <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_ready <= 1'b0;
            fetch_fault <= 1'b0;
            data_ready  <= 1'b0;
            data_fault  <= 1'b0;

            if (state == BUSY)
                wd_cnt <= wd_cnt + 32'd1;

            if (do_issue) begin
                bus_start_request  <= 1'b1;
                bus_target_address <= sel_addr[ADDR_W-1:0];
                bus_num_bytes      <= sel_size;
                bus_is_write       <= sel_data & data_we;
                bus_write_value    <= (sel_data && data_we) ? data_wdata : 32'd0;
                grant_data         <= sel_data;
                cur_we             <= sel_data & data_we;
                cur_funct3         <= sel_data ? data_funct3 : F3_LW;
                wd_cnt             <= 32'd0;
            end

            if (do_reject) begin
                if (sel_data) begin
                    data_ready <= 1'b1;
                    data_fault <= 1'b1;
                    data_rdata <= 32'd0;
                end else begin
                    fetch_ready <= 1'b1;
                    fetch_fault <= 1'b1;
                    fetch_instr <= 32'd0;
                end
            end

            if (do_done || do_timeout) begin
                bus_start_request <= 1'b0;
                if (grant_data) begin
                    data_ready <= 1'b1;
                    data_fault <= do_timeout;
                    data_rdata <= (do_done && !cur_we) ? ext_data : 32'd0;
                end else begin
                    fetch_ready <= 1'b1;
                    fetch_fault <= do_timeout;
                    fetch_instr <= do_done ? ext_data : 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    localparam int ADDR_W = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [31:0]       fetch_addr = 32'd0;
    logic              fetch_ready;
    logic [31:0]       fetch_instr;
    logic              fetch_fault;
    logic              data_req = 1'b0;
    logic              data_we = 1'b0;
    logic [2:0]        data_funct3 = 3'd0;
    logic [31:0]       data_addr = 32'd0;
    logic [31:0]       data_wdata = 32'd0;
    logic              data_ready;
    logic [31:0]       data_rdata;
    logic              data_fault;
    logic              bus_start_request;
    logic [ADDR_W-1:0] bus_target_address;
    logic [2:0]        bus_num_bytes;
    logic              bus_is_write;
    logic [31:0]       bus_write_value;
    logic              bus_request_done = 1'b0;
    logic [31:0]       bus_fetched_value = 32'd0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_data;
        logic        fault;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_req          (fetch_req),
        .fetch_addr         (fetch_addr),
        .fetch_ready        (fetch_ready),
        .fetch_instr        (fetch_instr),
        .fetch_fault        (fetch_fault),
        .data_req           (data_req),
        .data_we            (data_we),
        .data_funct3        (data_funct3),
        .data_addr          (data_addr),
        .data_wdata         (data_wdata),
        .data_ready         (data_ready),
        .data_rdata         (data_rdata),
        .data_fault         (data_fault),
        .bus_start_request  (bus_start_request),
        .bus_target_address (bus_target_address),
        .bus_num_bytes      (bus_num_bytes),
        .bus_is_write       (bus_is_write),
        .bus_write_value    (bus_write_value),
        .bus_request_done   (bus_request_done),
        .bus_fetched_value  (bus_fetched_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare one expected response whenever a ready pulse appears
    always @(negedge clk) begin
        if (rst_n && (fetch_ready || data_ready)) begin
            exp_t e;
            chk("one_resp_per_cycle", {31'd0, fetch_ready & data_ready}, 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_resp observed fetch_ready=%b data_ready=%b expected none", fetch_ready, data_ready);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_port", {31'd0, data_ready}, {31'd0, e.is_data});
                chk("resp_fault", {31'd0, data_ready ? data_fault : fetch_fault}, {31'd0, e.fault});
                chk("resp_value", data_ready ? data_rdata : fetch_instr, e.val);
            end
        end
    end

    // Acts as mem_bus: waits for start, holds done off for lat-1 cycles, then completes
    task automatic bus_txn(input int lat, input logic [31:0] val, output int waited);
        waited = 0;
        while (!bus_start_request && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("start_rise", {31'd0, bus_start_request}, 32'd1);
        for (int i = 1; i <= lat; i++) begin
            chk("start_held", {31'd0, bus_start_request}, 32'd1);
            if (i == lat) begin
                bus_request_done  = 1'b1;
                bus_fetched_value = val;
            end
            @(negedge clk);
        end
        chk("start_drop", {31'd0, bus_start_request}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive_data(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        data_req = 1'b1; data_we = we; data_funct3 = f3; data_addr = a; data_wdata = wd;
    endtask

    initial begin
        int w;
        int n;

        // Reset state
        idle(3);
        chk("rst_start", {31'd0, bus_start_request}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_data_ready", {31'd0, data_ready}, 32'd0);
        chk("rst_addr", {14'd0, bus_target_address}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: fetch, bus completes in its 5th cycle
        fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
        sb.push_back('{1'b0, 1'b0, 32'h00A0_0093});
        bus_txn(5, 32'h00A0_0093, w);
        chk("f1_ready", {31'd0, fetch_ready}, 32'd1);
        chk("f1_addr", {14'd0, bus_target_address}, 32'h0000_0100);
        chk("f1_nbytes", {29'd0, bus_num_bytes}, 32'd4);
        chk("f1_write", {31'd0, bus_is_write}, 32'd0);
        fetch_req = 1'b0; bus_request_done = 1'b0;
        idle(2);

        // 2: LB then LBU of 0x80
        drive_data(1'b0, 3'b000, 32'h0001_0003, 32'd0);
        sb.push_back('{1'b1, 1'b0, 32'hFFFF_FF80});
        bus_txn(1, 32'h0000_0080, w);
        chk("lb_addr", {14'd0, bus_target_address}, 32'h0001_0003);
        chk("lb_nbytes", {29'd0, bus_num_bytes}, 32'd1);
        data_req = 1'b0; bus_request_done = 1'b0;
        idle(2);
        drive_data(1'b0, 3'b100, 32'h0001_0003, 32'd0);
        sb.push_back('{1'b1, 1'b0, 32'h0000_0080});
        bus_txn(2, 32'h0000_0080, w);
        data_req = 1'b0; bus_request_done = 1'b0;
        idle(2);

        // LH sign-extends from bit 15
        drive_data(1'b0, 3'b001, 32'h0001_0006, 32'd0);
        sb.push_back('{1'b1, 1'b0, 32'hFFFF_8001});
        bus_txn(1, 32'h0000_8001, w);
        chk("lh_nbytes", {29'd0, bus_num_bytes}, 32'd2);
        data_req = 1'b0; bus_request_done = 1'b0;
        idle(2);

        // 3: SH store
        drive_data(1'b1, 3'b001, 32'h0002_0004, 32'h1234_ABCD);
        sb.push_back('{1'b1, 1'b0, 32'h0000_0000});
        bus_txn(3, 32'hDEAD_BEEF, w);
        chk("sh_addr", {14'd0, bus_target_address}, 32'h0002_0004);
        chk("sh_write", {31'd0, bus_is_write}, 32'd1);
        chk("sh_nbytes", {29'd0, bus_num_bytes}, 32'd2);
        chk("sh_wvalue", bus_write_value, 32'h1234_ABCD);
        data_req = 1'b0; bus_request_done = 1'b0;
        idle(2);

        // 4: misaligned LW and out-of-range fetch are rejected without bus activity
        drive_data(1'b0, 3'b010, 32'h0001_0002, 32'd0);
        sb.push_back('{1'b1, 1'b1, 32'h0000_0000});
        @(negedge clk);
        chk("lw_mis_ready", {31'd0, data_ready}, 32'd1);
        chk("lw_mis_nostart", {31'd0, bus_start_request}, 32'd0);
        data_req = 1'b0;
        @(negedge clk);
        chk("lw_mis_nostart2", {31'd0, bus_start_request}, 32'd0);
        idle(1);
        fetch_req = 1'b1; fetch_addr = 32'h0004_0000;
        sb.push_back('{1'b0, 1'b1, 32'h0000_0000});
        @(negedge clk);
        chk("f_oor_ready", {31'd0, fetch_ready}, 32'd1);
        chk("f_oor_nostart", {31'd0, bus_start_request}, 32'd0);
        fetch_req = 1'b0;
        @(negedge clk);
        chk("f_oor_nostart2", {31'd0, bus_start_request}, 32'd0);
        idle(1);

        // 5: simultaneous requests - data first, fetch after done low plus an idle cycle
        drive_data(1'b0, 3'b010, 32'h0001_0008, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h0000_0104;
        sb.push_back('{1'b1, 1'b0, 32'h1122_3344});
        sb.push_back('{1'b0, 1'b0, 32'h0000_0013});
        bus_txn(2, 32'h1122_3344, w);
        chk("arb_data_addr", {14'd0, bus_target_address}, 32'h0001_0008);
        data_req = 1'b0;
        idle(2);
        chk("arb_release_hold", {31'd0, bus_start_request}, 32'd0);
        bus_request_done = 1'b0;
        bus_txn(3, 32'h0000_0013, w);
        chk("arb_fetch_gap", w, 32'd2);
        chk("arb_fetch_addr", {14'd0, bus_target_address}, 32'h0000_0104);
        fetch_req = 1'b0; bus_request_done = 1'b0;
        idle(2);

        // 6a: watchdog - bus never completes
        drive_data(1'b0, 3'b010, 32'h0001_0010, 32'd0);
        sb.push_back('{1'b1, 1'b1, 32'h0000_0000});
        n = 0;
        while (!bus_start_request && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (bus_start_request && n < 40) begin @(negedge clk); n++; end
        chk("wd_start_cycles", n, 32'd8);
        chk("wd_ready", {31'd0, data_ready}, 32'd1);
        chk("wd_fault", {31'd0, data_fault}, 32'd1);
        data_req = 1'b0;
        idle(3);

        // 6b: reset in the middle of a transaction aborts silently
        fetch_req = 1'b1; fetch_addr = 32'h0000_0108;
        n = 0;
        while (!bus_start_request && n < 20) begin @(negedge clk); n++; end
        chk("rstb_start", {31'd0, bus_start_request}, 32'd1);
        idle(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstb_start_drop", {31'd0, bus_start_request}, 32'd0);
        chk("rstb_no_ready", {31'd0, fetch_ready}, 32'd0);
        fetch_req = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(4);
        chk("rstb_still_idle", {31'd0, bus_start_request | fetch_ready}, 32'd0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
